// File: rtl/seven_seg_scan.sv
// Four-digit common-anode seven-segment scanner: register, mode, serial bit, step count.
// Optional SEG_DP_HEARTBEAT_EN: decimal point on digit0 blinks from a full-scan counter.
module seven_seg_scan #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] data_in,
  input  logic [1:0] mode_in,
  input  logic       serial_in,
  input  logic       step_pulse,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);

  typedef enum logic {
    DRIVE = 1'b0,
    BLANK = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       idx, idx_n;
  logic             wrap;
  logic [3:0]       step_cnt;

  logic [3:0] snap_data, snap_data_n;
  logic [1:0] snap_mode, snap_mode_n;
  logic       snap_ser, snap_ser_n;
  logic [3:0] snap_step, snap_step_n;
  logic       snap_load;

  logic [3:0] nib;
  logic [3:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n;

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'ha: s = 7'h08;
      4'hb: s = 7'h03;
      4'hc: s = 7'h46;
      4'hd: s = 7'h21;
      4'he: s = 7'h06;
      default: s = 7'h0e;
    endcase
    return s;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= DRIVE;
      cnt   <= '0;
      idx   <= 2'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
    end
  end

  // With no blank phase the DRIVE terminal count advances the digit directly.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CNT_W'(1);
    idx_n   = idx;
    wrap    = 1'b0;
    case (state)
      DRIVE: begin
        if (cnt == DRIVE_LAST) begin
          cnt_n = '0;
          if (BLANK_CYCLES == 0) begin
            idx_n = idx + 2'd1;
            wrap  = (idx == 2'd3);
          end else begin
            state_n = BLANK;
          end
        end
      end
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          cnt_n   = '0;
          idx_n   = idx + 2'd1;
          wrap    = (idx == 2'd3);
          state_n = DRIVE;
        end
      end
      default: begin
        state_n = DRIVE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      step_cnt <= 4'd0;
    end else if (step_pulse) begin
      step_cnt <= step_cnt + 4'd1;
    end
  end

  // The snapshot taken on a digit's first DRIVE cycle feeds the output register on that same edge.
  assign snap_load   = (state == DRIVE) && (cnt == '0);
  assign snap_data_n = snap_load ? data_in   : snap_data;
  assign snap_mode_n = snap_load ? mode_in   : snap_mode;
  assign snap_ser_n  = snap_load ? serial_in : snap_ser;
  assign snap_step_n = snap_load ? step_cnt  : snap_step;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      snap_data <= 4'd0;
      snap_mode <= 2'd0;
      snap_ser  <= 1'b0;
      snap_step <= 4'd0;
    end else begin
      snap_data <= snap_data_n;
      snap_mode <= snap_mode_n;
      snap_ser  <= snap_ser_n;
      snap_step <= snap_step_n;
    end
  end

`ifdef SEG_DP_HEARTBEAT_EN
  logic [7:0] scan_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scan_cnt <= 8'd0;
    end else if (wrap) begin
      scan_cnt <= scan_cnt + 8'd1;
    end
  end

  assign dp_n = ~((state == DRIVE) && (idx == 2'd0) && scan_cnt[7]);
`else
  assign dp_n = 1'b1;
`endif

  always_comb begin
    nib = 4'd0;
    case (idx)
      2'd0: nib = snap_data_n;
      2'd1: nib = {2'b00, snap_mode_n};
      2'd2: nib = {3'b000, snap_ser_n};
      default: nib = snap_step_n;
    endcase
  end

  always_comb begin
    an_n  = 4'b1111;
    seg_n = 7'h7f;
    if (state == DRIVE) begin
      an_n  = ~(4'b0001 << idx);
      seg_n = hex_decode(nib);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      an  <= 4'b1111;
      seg <= 7'h7f;
      dp  <= 1'b1;
    end else begin
      an  <= an_n;
      seg <= seg_n;
      dp  <= dp_n;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan at REFRESH_DIV=4, BLANK_CYCLES=2 (24-cycle scan).
// Build with SEG_DP_HEARTBEAT_EN defined to expect the digit0 heartbeat on dp.
module tb_seven_seg_scan;

  logic       clock;
  logic       reset;
  logic [3:0] data_in;
  logic [1:0] mode_in;
  logic       serial_in;
  logic       step_pulse;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  seven_seg_scan #(
    .REFRESH_DIV (4),
    .BLANK_CYCLES(2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .data_in   (data_in),
    .mode_in   (mode_in),
    .serial_in (serial_in),
    .step_pulse(step_pulse),
    .seg       (seg),
    .dp        (dp),
    .an        (an)
  );

  // Clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Expected outputs packed as {an, seg, dp}
  logic [11:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  string       phase = "init";

  logic [6:0] hex_tab[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e};
  logic [3:0] an_tab[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  // Bench-side view of what the display should hold
  int         t;
  logic [3:0] m_step;
  logic [3:0] s_data;
  logic [1:0] s_mode;
  logic       s_ser;
  logic [3:0] s_step;

  // Monitor: outputs are sampled mid-cycle
  always @(negedge clock) begin
    logic [11:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({an, seg, dp} !== e) begin
        n_bad++;
        $display("FAIL %s t=%0d: got an=%b seg=%h dp=%b, want an=%b seg=%h dp=%b",
                 phase, t, an, seg, dp, e[11:8], e[7:1], e[0]);
      end
    end
  end

  // One clock with reset held: display must be blank by mid-cycle
  task automatic reset_cycle();
    @(posedge clock);
    #1;
    reset = 1'b1;
    exp_q.push_back({4'b1111, 7'h7f, 1'b1});
  endtask

  // One running clock; pushes the output expected for the cycle after this edge
  task automatic cycle();
    int p, dig, w, scan;
    logic [3:0] nib;
    logic [3:0] an_e;
    logic [6:0] seg_e;
    logic       dp_e;
    @(posedge clock);
    p    = t % 24;
    dig  = p / 6;
    w    = p % 6;
    scan = t / 24;
    if (w == 0) begin
      s_data = data_in;
      s_mode = mode_in;
      s_ser  = serial_in;
      s_step = m_step;
    end
    if (step_pulse) m_step = m_step + 4'd1;
    #1;
    an_e  = 4'b1111;
    seg_e = 7'h7f;
    dp_e  = 1'b1;
    if (w < 4) begin
      case (dig)
        0: nib = s_data;
        1: nib = {2'b00, s_mode};
        2: nib = {3'b000, s_ser};
        default: nib = s_step;
      endcase
      an_e  = an_tab[dig];
      seg_e = hex_tab[nib];
`ifdef SEG_DP_HEARTBEAT_EN
      if (dig == 0 && scan[7]) dp_e = 1'b0;
`endif
    end
    exp_q.push_back({an_e, seg_e, dp_e});
    t++;
  endtask

  initial begin
    reset      = 1'b1;
    data_in    = 4'h0;
    mode_in    = 2'b00;
    serial_in  = 1'b0;
    step_pulse = 1'b0;
    t          = 0;
    m_step     = 4'd0;
    s_data     = 4'd0;
    s_mode     = 2'd0;
    s_ser      = 1'b0;
    s_step     = 4'd0;

    phase = "reset_hold";
    repeat (3) reset_cycle();
    reset = 1'b0;

    phase = "zero_scan";
    repeat (24) cycle();

    phase = "a31_scan";
    data_in   = 4'ha;
    mode_in   = 2'b11;
    serial_in = 1'b1;
    repeat (24) cycle();

    phase = "midchange";
    data_in = 4'h3;
    repeat (2) cycle();
    data_in = 4'h5;
    repeat (28) cycle();

    phase = "steps17";
    for (int i = 0; i < 17; i++) begin
      step_pulse = 1'b1;
      cycle();
    end
    step_pulse = 1'b0;
    cycle();
    step_pulse = 1'b1;
    cycle();
    step_pulse = 1'b0;
    cycle();
    step_pulse = 1'b1;
    cycle();
    step_pulse = 1'b0;
    repeat (48) cycle();

    phase = "reset_mid";
    for (int i = 0; i < 24 && (t % 24) != 14; i++) cycle();
    repeat (2) reset_cycle();
    reset   = 1'b0;
    t       = 0;
    m_step  = 4'd0;
    data_in = 4'h7;
    mode_in = 2'b10;
    serial_in = 1'b0;
    phase = "after_reset";
    repeat (24) cycle();

    phase = "heartbeat";
    repeat (259 * 24) cycle();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
Downstream display stage for the shift-register lab. Consumes the 4-bit register output, the 2-bit mode select, the serial input bit and the debounced step pulse. Drives the board's 4-digit common-anode seven-segment display, one digit at a time.
- Digit0 = register value (hex).
- Digit1 = mode.
- Digit2 = serial bit.
- Digit3 = step count mod 16.

Parameters:
REFRESH_DIV, 100000, clock cycles each digit is driven (100 MHz -> 1 ms per digit).
BLANK_CYCLES, 1000, clock cycles all anodes are off between digits (anti-ghosting); 0 = no blank phase.

Ports:
clock  input  1  system clock (board oscillator)
reset  input  1  asynchronous, active-high reset
data_in  input  4  shift-register parallel output
mode_in  input  2  mode select value
serial_in  input  1  serial input bit
step_pulse  input  1  single-cycle debounced step pulse
seg  output  7  segments, active-low, seg[6]=g .. seg[0]=a
dp  output  1  decimal point, active-low
an  output  4  digit anodes, active-low, an[0]=rightmost digit

Behaviour:
- Reset and clocking:
  - One clock; reset is asynchronous and active-high.
  - On reset: an=4'b1111, seg=7'b1111111, dp=1, digit index=0, step count=0, phase counter=0, state=DRIVE.
  - Reset mid-scan clears all of these immediately. No partial digit completes.
- States:
  - DRIVE: phase counter runs 0..REFRESH_DIV-1. At the terminal count, go to BLANK and clear the counter. If BLANK_CYCLES==0, go directly to DRIVE with digit index+1 instead.
  - BLANK: counter runs 0..BLANK_CYCLES-1. At the terminal count, digit index+1 (wraps 3->0), clear the counter, go to DRIVE.
- Input capture:
  - data_in, mode_in, serial_in and the step count are latched into a snapshot register on the first cycle of each DRIVE phase.
  - The value shown is stable for the whole digit even if inputs change mid-digit.
- Outputs:
  - All outputs are registered, with 1-cycle latency from the state/snapshot registers.
  - DRIVE: an = ~(4'b0001 << index); seg = hex decode of the selected nibble.
  - BLANK: an=4'b1111, seg=7'b1111111, dp=1.
- Nibbles: digit0 = data_in; digit1 = {2'b00, mode_in}; digit2 = {3'b000, serial_in}; digit3 = step count.
- Hex decode (gfedcba, active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
- Step count:
  - 4-bit; increments on every clock with step_pulse=1; wraps F->0.
  - Counting is independent of scan state.
  - A step arriving on the snapshot cycle is counted but not shown until the next digit3 DRIVE.
- Exactly one anode is low at any time in DRIVE; never more than one.

Optional Feature:
SEG_DP_HEARTBEAT_EN
- Defined: an 8-bit full-scan counter increments each time the index wraps 3->0. dp is low during digit0 DRIVE when counter bit 7 is 1, giving a visible ~1 Hz-class heartbeat. The counter resets to 0.
- Undefined: dp is constantly 1 and no scan counter exists.

Test Plan:
All scenarios use REFRESH_DIV=4 and BLANK_CYCLES=2.
- Reset held, then released -> an=1111, seg=7F, dp=1 during reset. One cycle after release: an=1110, seg=40 (data_in=0).
- data_in=4'hA, mode_in=2'b11, serial_in=1, no steps -> over 24 cycles: an=1110 seg=08, an=1101 seg=30, an=1011 seg=79, an=0111 seg=40. Each digit lasts 4 cycles, with 2 cycles of an=1111 between digits.
- Change data_in 3->5 on cycle 2 of a digit0 DRIVE -> seg stays 30 for that digit; the next digit0 shows 12.
- 17 step pulses -> digit3 shows 1 (wrap F->0 observed at pulse 16). Two pulses 1 cycle apart -> count +2.
- Assert reset during a digit2 DRIVE -> outputs blank at once. After release, scan restarts at digit0 with step count 0.
- SEG_DP_HEARTBEAT_EN defined -> dp=1 for the first 128 full scans. dp=0 during digit0 DRIVE for scans 128-255. Undefined -> dp=1 always.
